stopwatch_timer_core: RTL and testbench
=======================================

# stopwatch_timer_core

Parametrised stopwatch/countdown engine with lap capture. It replaces the free-running millisecond counter with a prescaled centisecond tick, an explicit run/pause/expire state machine, and a FIFO lap buffer of configurable depth. It sits between the debounced button front end, which delivers single-cycle pulses, and the display/time-formatting logic, which consumes `countValue` and `lapData`.

## Interface
- `COUNT_WIDTH`, 32: width of the centisecond count and of the lap entries.
- `TICK_DIV`, 1000000: clock cycles per centisecond tick (≥2).
- `LAP_DEPTH`, 8: lap FIFO depth (power of 2, ≥2).

- `clockSignal` in 1: sole clock, rising edge.
- `resetN` in 1: asynchronous, active-low reset.
- `modeSelect` in 1: 0 = stopwatch, 1 = countdown; sampled only in IDLE.
- `startStopPulse` in 1: one-cycle pulse for start, pause or resume.
- `splitResetPulse` in 1: one-cycle pulse for lap, reset or preset load.
- `loadValue` in COUNT_WIDTH: countdown preset in centiseconds.
- `lapReadPulse` in 1: pops the FIFO head.
- `countValue` out COUNT_WIDTH: current count.
- `activeMode` out 1: latched mode.
- `running` out 1: high in RUNNING.
- `tickPulse` out 1: one cycle, coincident with each `countValue` update.
- `ringSound` out 1: countdown expired.
- `lapValid` out 1: FIFO not empty.
- `lapData` out COUNT_WIDTH: FIFO head, first-word fall-through.
- `lapCount` out $clog2(LAP_DEPTH+1): number of entries in the FIFO.
- `lapOverflow` out 1: sticky flag; a split was dropped because the FIFO was full.

## Operation
- **States:** IDLE, RUNNING, PAUSED, EXPIRED.
- **Reset:** state IDLE, all outputs 0, prescaler 0, preset register 0, FIFO empty.
- **IDLE:**
  - `activeMode <= modeSelect` every cycle.
  - Split with mode 1: preset register and `countValue` <= `loadValue`.
  - Split with mode 0: `countValue` <= 0; FIFO and `lapOverflow` cleared.
  - Start with mode 0 → RUNNING.
  - Start with mode 1 and `countValue` ≠ 0 → RUNNING. With `countValue` = 0 the start is ignored.
- **RUNNING:**
  - Prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1 it wraps to 0 and a tick occurs.
  - Tick in mode 0: `countValue` + 1, saturating at all-ones. The prescaler keeps running at saturation.
  - Tick in mode 1: `countValue` − 1. On reaching 0 → EXPIRED.
  - Start → PAUSED.
  - Split pushes the current `countValue` into the FIFO. If the FIFO is full, the push is dropped and `lapOverflow` <= 1.
- **PAUSED:**
  - Prescaler holds its value.
  - Start → RUNNING, resuming the partial tick.
  - Split → IDLE. In mode 0: `countValue` = 0 and FIFO cleared. In mode 1: `countValue` = preset.
- **EXPIRED:**
  - `ringSound` = 1, `running` = 0.
  - Start or split → IDLE, `ringSound` <= 0, `countValue` <= preset.
- **Prescaler:** cleared in IDLE and EXPIRED.
- **Simultaneous start and split:** start wins and the split is ignored. In EXPIRED both act as acknowledge.
- **Tick and start in the same cycle:** the tick is applied and the state changes. The prescaler has already wrapped to 0.
- **Countdown tick to 0 and start in the same cycle:** → EXPIRED; the start is ignored.
- **FIFO pop:** a pop with `lapValid` high advances the head. A pop on empty is ignored.
- **Push and pop in the same cycle:** both are performed. On a full FIFO this succeeds with no overflow.
- **Mode change outside IDLE:** ignored until the next return to IDLE.

## Timing
- All outputs are registered and update on the clock edge that samples the event.
- Start sampled at edge k: `running` = 1 after edge k. First tick at edge k+TICK_DIV, so the `countValue` change and `tickPulse` are visible after that edge.
- Pause at edge k: `running` = 0 after edge k. After resume at edge j, the next tick comes TICK_DIV − p edges after j, where p is the held prescaler value.
- Split in RUNNING at edge k: `lapValid` / `lapCount` update after edge k. `lapData` is the count value before edge k.
- Expiry: `countValue` = 0, `ringSound` = 1 and `running` = 0 all become visible after the same edge.
- `resetN` low: all state clears immediately, independent of the clock, including mid-count.

## Test plan
All scenarios use TICK_DIV=4, COUNT_WIDTH=8, LAP_DEPTH=4.

1. Stopwatch: start, wait 40 clocks → `countValue` = 10 with `tickPulse` seen 10 times. Pause, wait 100 clocks → holds 10. Resume → 11 after 4 clocks.
2. Laps: 5 splits while running at counts 2,3,4,5,6 → `lapCount` = 4, `lapOverflow` = 1. Four pops return 2,3,4,5, then `lapValid` = 0.
3. Countdown: `modeSelect` = 1, `loadValue` = 3, split, start → after 12 clocks `countValue` = 0, `ringSound` = 1, `running` = 0. Then a start pulse → `ringSound` = 0, `countValue` = 3, IDLE.
4. Countdown with preset 0: start → `running` stays 0. Start and split asserted together in RUNNING → PAUSED and no lap pushed.
5. Saturation: stopwatch run for 1100 clocks → `countValue` = 255 and held.
6. Reset mid-run: assert `resetN` = 0 between clock edges at count 7 with laps stored → all outputs 0 immediately. After release, the FIFO is empty and the state is IDLE.

Source files
------------

// File: rtl/stopwatch_timer_core.sv
// Stopwatch / countdown engine: prescaled centisecond tick,
// run/pause/expire control and a first-word fall-through lap FIFO.
//
// Ports:
//   clockSignal      rising-edge clock
//   resetN           async active-low reset
//   modeSelect       0 stopwatch, 1 countdown (sampled in IDLE)
//   startStopPulse   start / pause / resume / acknowledge
//   splitResetPulse  lap / reset / preset load / acknowledge
//   loadValue        countdown preset (centiseconds)
//   lapReadPulse     pop FIFO head
//   countValue       current count
//   activeMode       latched mode
//   running          high while counting
//   tickPulse        one cycle per count update
//   ringSound        countdown expired
//   lapValid         FIFO not empty
//   lapData          FIFO head
//   lapCount         FIFO occupancy
//   lapOverflow      sticky: a lap was dropped on a full FIFO

module stopwatch_timer_core #(
  parameter int COUNT_WIDTH = 32,
  parameter int TICK_DIV    = 1000000,
  parameter int LAP_DEPTH   = 8
) (
  input  logic                           clockSignal,
  input  logic                           resetN,
  input  logic                           modeSelect,
  input  logic                           startStopPulse,
  input  logic                           splitResetPulse,
  input  logic [COUNT_WIDTH-1:0]         loadValue,
  input  logic                           lapReadPulse,
  output logic [COUNT_WIDTH-1:0]         countValue,
  output logic                           activeMode,
  output logic                           running,
  output logic                           tickPulse,
  output logic                           ringSound,
  output logic                           lapValid,
  output logic [COUNT_WIDTH-1:0]         lapData,
  output logic [$clog2(LAP_DEPTH+1)-1:0] lapCount,
  output logic                           lapOverflow
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = $clog2(LAP_DEPTH + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAP_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAP_FULL = CW'(LAP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXP
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [COUNT_WIDTH-1:0] preset_q, preset_d;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic                   mode_d;
  logic                   tick;
  logic                   expire;

  logic                   lap_push;
  logic                   fifo_clr;
  logic                   ovf_clr;
  logic                   lap_pop;
  logic                   lap_wr;
  logic                   lap_full;
  logic                   ovf_d;
  logic [CW-1:0]          lcnt_d;

  logic [COUNT_WIDTH-1:0] mem [LAP_DEPTH];
  logic [AW-1:0]          rd_q;
  logic [AW-1:0]          wr_q;

  // control FSM: next state, count, prescaler
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    cnt_d    = countValue;
    mode_d   = activeMode;
    tick     = 1'b0;
    expire   = 1'b0;
    lap_push = 1'b0;
    fifo_clr = 1'b0;
    ovf_clr  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        mode_d  = modeSelect;
        if (startStopPulse) begin
          // a countdown from zero has nothing to count
          if (!modeSelect || countValue != '0) begin
            state_d = S_RUN;
          end
        end else if (splitResetPulse) begin
          if (modeSelect) begin
            preset_d = loadValue;
            cnt_d    = loadValue;
          end else begin
            cnt_d    = '0;
            fifo_clr = 1'b1;
            ovf_clr  = 1'b1;
          end
        end
      end
      S_RUN: begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PRESC_ONE;
        if (tick) begin
          if (!activeMode) begin
            if (countValue != '1) begin
              cnt_d = countValue + CNT_ONE;
            end
          end else begin
            cnt_d = countValue - CNT_ONE;
            if (countValue == CNT_ONE) begin
              expire  = 1'b1;
              state_d = S_EXP;
            end
          end
        end
        // expiry swallows a coincident start
        if (startStopPulse) begin
          if (!expire) begin
            state_d = S_PAUSE;
          end
        end else if (splitResetPulse) begin
          lap_push = 1'b1;
        end
      end
      S_PAUSE: begin
        if (startStopPulse) begin
          state_d = S_RUN;
        end else if (splitResetPulse) begin
          state_d = S_IDLE;
          presc_d = '0;
          if (activeMode) begin
            cnt_d = preset_q;
          end else begin
            cnt_d    = '0;
            fifo_clr = 1'b1;
          end
        end
      end
      S_EXP: begin
        presc_d = '0;
        if (startStopPulse || splitResetPulse) begin
          state_d = S_IDLE;
          cnt_d   = preset_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // lap FIFO bookkeeping; a pop frees room for a same-cycle push
  always_comb begin
    lap_full = (lapCount == LAP_FULL);
    lap_pop  = lapReadPulse && lapValid && !fifo_clr;
    lap_wr   = lap_push && (!lap_full || lap_pop);
    ovf_d    = lapOverflow;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (lap_push && !lap_wr) begin
      ovf_d = 1'b1;
    end
    lcnt_d = lapCount;
    if (fifo_clr) begin
      lcnt_d = '0;
    end else if (lap_wr && !lap_pop) begin
      lcnt_d = lapCount + LAP_ONE;
    end else if (!lap_wr && lap_pop) begin
      lcnt_d = lapCount - LAP_ONE;
    end
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      preset_q   <= '0;
      countValue <= '0;
      activeMode <= 1'b0;
      running    <= 1'b0;
      ringSound  <= 1'b0;
      tickPulse  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      preset_q   <= preset_d;
      countValue <= cnt_d;
      activeMode <= mode_d;
      running    <= (state_d == S_RUN);
      ringSound  <= (state_d == S_EXP);
      tickPulse  <= tick;
    end
  end

  always_ff @(posedge clockSignal or negedge resetN) begin
    if (!resetN) begin
      rd_q        <= '0;
      wr_q        <= '0;
      lapCount    <= '0;
      lapValid    <= 1'b0;
      lapOverflow <= 1'b0;
    end else begin
      lapCount    <= lcnt_d;
      lapValid    <= (lcnt_d != '0);
      lapOverflow <= ovf_d;
      if (fifo_clr) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (lap_wr) begin
          wr_q <= wr_q + PTR_ONE;
        end
        if (lap_pop) begin
          rd_q <= rd_q + PTR_ONE;
        end
      end
    end
  end

  // storage needs no reset: lapData is masked while empty
  always_ff @(posedge clockSignal) begin
    if (lap_wr) begin
      mem[wr_q] <= countValue;
    end
  end

  assign lapData = lapValid ? mem[rd_q] : '0;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: directed scenarios with literal
// expectations plus random pulses against a behavioural model.

module tb_stopwatch_timer_core;

  localparam int TD  = 4;
  localparam int MAXC = 255;
  localparam int DEPTH = 4;

  logic       clk;
  logic       resetN;
  logic       modeSelect;
  logic       ss;
  logic       sr;
  logic [7:0] loadValue;
  logic       rd;
  logic [7:0] countValue;
  logic       activeMode;
  logic       running;
  logic       tickPulse;
  logic       ringSound;
  logic       lapValid;
  logic [7:0] lapData;
  logic [2:0] lapCount;
  logic       lapOverflow;

  int checks = 0;
  int errors = 0;
  int ntick = 0;

  stopwatch_timer_core #(
    .COUNT_WIDTH(8),
    .TICK_DIV(TD),
    .LAP_DEPTH(DEPTH)
  ) dut (
    .clockSignal(clk),
    .resetN(resetN),
    .modeSelect(modeSelect),
    .startStopPulse(ss),
    .splitResetPulse(sr),
    .loadValue(loadValue),
    .lapReadPulse(rd),
    .countValue(countValue),
    .activeMode(activeMode),
    .running(running),
    .tickPulse(tickPulse),
    .ringSound(ringSound),
    .lapValid(lapValid),
    .lapData(lapData),
    .lapCount(lapCount),
    .lapOverflow(lapOverflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d",
               nm, $time, act, exp);
    end
  endtask

  // behavioural model: elapsed running cycles drive the ticks
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mst_t;
  mst_t m_st = M_IDLE;
  bit   m_mode = 0;
  int   m_cnt = 0;
  int   m_preset = 0;
  int   m_acc = 0;
  bit   m_tick = 0;
  bit   m_ovf = 0;
  int   q[$];

  always @(posedge clk or negedge resetN) begin
    int  pushv;
    bit  pop, clr, clr_ovf, expd, start, split;
    if (!resetN) begin
      m_st = M_IDLE; m_mode = 0; m_cnt = 0; m_preset = 0;
      m_acc = 0; m_tick = 0; m_ovf = 0; q.delete();
    end else begin
      start = ss; split = sr;
      pop = rd && (q.size() > 0);
      pushv = -1; clr = 0; clr_ovf = 0; expd = 0;
      m_tick = 0;
      case (m_st)
        M_IDLE: begin
          m_mode = modeSelect; m_acc = 0;
          if (start) begin
            if (!modeSelect || m_cnt != 0) m_st = M_RUN;
          end else if (split) begin
            if (modeSelect) begin
              m_preset = loadValue; m_cnt = loadValue;
            end else begin
              m_cnt = 0; clr = 1; clr_ovf = 1;
            end
          end
        end
        M_RUN: begin
          int old;
          old = m_cnt;
          m_acc++;
          if (m_acc % TD == 0) begin
            m_tick = 1;
            if (!m_mode) m_cnt = (m_cnt < MAXC) ? m_cnt + 1 : MAXC;
            else begin
              m_cnt--;
              if (m_cnt == 0) begin m_st = M_EXP; expd = 1; end
            end
          end
          if (start) begin
            if (!expd) m_st = M_PAUSE;
          end else if (split) pushv = old;
        end
        M_PAUSE: begin
          if (start) m_st = M_RUN;
          else if (split) begin
            m_st = M_IDLE; m_acc = 0;
            if (m_mode) m_cnt = m_preset;
            else begin m_cnt = 0; clr = 1; end
          end
        end
        M_EXP: begin
          m_acc = 0;
          if (start || split) begin m_st = M_IDLE; m_cnt = m_preset; end
        end
      endcase
      if (clr) begin
        q.delete();
        if (clr_ovf) m_ovf = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (pushv >= 0) begin
          if (q.size() < DEPTH) q.push_back(pushv);
          else m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cmp("countValue", countValue, m_cnt);
    cmp("activeMode", activeMode, m_mode);
    cmp("running", running, int'(m_st == M_RUN));
    cmp("tickPulse", tickPulse, m_tick);
    cmp("ringSound", ringSound, int'(m_st == M_EXP));
    cmp("lapValid", lapValid, int'(q.size() > 0));
    cmp("lapData", lapData, (q.size() > 0) ? q[0] : 0);
    cmp("lapCount", lapCount, q.size());
    cmp("lapOverflow", lapOverflow, m_ovf);
    if (tickPulse) ntick++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ss = 0; sr = 0; rd = 0;
    end
  endtask

  initial begin
    int t0;
    resetN = 1; modeSelect = 0; ss = 0; sr = 0; rd = 0;
    loadValue = 0;
    #1 resetN = 0;
    cyc(3);
    cmp("reset countValue", countValue, 0);
    cmp("reset lapValid", lapValid, 0);
    resetN = 1;
    cyc(2);

    // 1: stopwatch, pause, resume
    t0 = ntick;
    ss = 1; cyc(1);
    cmp("s1 running", running, 1);
    cyc(40);
    cmp("s1 count40", countValue, 10);
    ss = 1; cyc(1);
    cmp("s1 ticks", ntick - t0, 10);
    cmp("s1 paused", running, 0);
    cyc(100);
    cmp("s1 hold", countValue, 10);
    ss = 1; cyc(1);
    cyc(4);
    cmp("s1 resume", countValue, 11);
    ss = 1; cyc(1);
    sr = 1; cyc(1);
    cmp("s1 cleared", countValue, 0);

    // 2: laps with overflow
    ss = 1; cyc(1);
    cyc(8);
    cmp("s2 count2", countValue, 2);
    for (int i = 0; i < 5; i++) begin
      sr = 1; cyc(1);
      cyc(3);
    end
    cmp("s2 lapCount", lapCount, 4);
    cmp("s2 overflow", lapOverflow, 1);
    ss = 1; cyc(1);
    for (int i = 0; i < 4; i++) begin
      cmp("s2 lapData", lapData, 2 + i);
      rd = 1; cyc(1);
    end
    cmp("s2 empty", lapValid, 0);
    sr = 1; cyc(1);
    sr = 1; cyc(1);
    cmp("s2 ovf clr", lapOverflow, 0);

    // 3: countdown to expiry
    modeSelect = 1; loadValue = 3; cyc(1);
    sr = 1; cyc(1);
    cmp("s3 load", countValue, 3);
    ss = 1; cyc(1);
    cyc(12);
    cmp("s3 zero", countValue, 0);
    cmp("s3 ring", ringSound, 1);
    cmp("s3 run", running, 0);
    ss = 1; cyc(1);
    cmp("s3 ack ring", ringSound, 0);
    cmp("s3 reload", countValue, 3);
    cmp("s3 mode", activeMode, 1);

    // 4: preset zero, start+split together
    loadValue = 0; sr = 1; cyc(1);
    ss = 1; cyc(1);
    cmp("s4 no start", running, 0);
    loadValue = 50; sr = 1; cyc(1);
    ss = 1; cyc(1);
    cyc(2);
    ss = 1; sr = 1; cyc(1);
    cmp("s4 paused", running, 0);
    cmp("s4 no lap", lapCount, 0);
    cmp("s4 hold", countValue, 50);
    sr = 1; cyc(1);
    cmp("s4 preset", countValue, 50);

    // 5: saturation
    modeSelect = 0; cyc(1);
    sr = 1; cyc(1);
    ss = 1; cyc(1);
    cyc(1100);
    cmp("s5 sat", countValue, 255);
    cyc(8);
    cmp("s5 held", countValue, 255);
    ss = 1; cyc(1);
    sr = 1; cyc(1);

    // 6: async reset mid-run
    ss = 1; cyc(1);
    cyc(4);
    sr = 1; cyc(1);
    cyc(3);
    sr = 1; cyc(1);
    cyc(19);
    cmp("s6 count7", countValue, 7);
    cmp("s6 laps", lapCount, 2);
    #2 resetN = 0;
    #1;
    cmp("s6 rst count", countValue, 0);
    cmp("s6 rst running", running, 0);
    cmp("s6 rst lapValid", lapValid, 0);
    cmp("s6 rst lapCount", lapCount, 0);
    cmp("s6 rst lapData", lapData, 0);
    cmp("s6 rst tick", tickPulse, 0);
    @(posedge clk); #1;
    resetN = 1;
    cyc(1);
    cmp("s6 empty", lapValid, 0);
    ss = 1; cyc(1);
    cmp("s6 idle start", running, 1);

    // random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      ss = ($urandom_range(19) == 0);
      sr = ($urandom_range(11) == 0);
      rd = ($urandom_range(7) == 0);
      if ($urandom_range(39) == 0) modeSelect = ~modeSelect;
      loadValue = 8'($urandom_range(15));
      if ($urandom_range(999) == 0) begin
        resetN = 0; #2 resetN = 1;
      end
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
